// File: rtl/full_adder_unit.sv
// Ripple-carry adder of WIDTH full-adder cells with an optional output register stage.
// {o_carry, o_sum} = i_bit1 + i_bit2 + i_carry at WIDTH+1 bits.
module full_adder_unit #(
  parameter int WIDTH      = 1,
  parameter int REGISTERED = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_bit1,
  input  logic [WIDTH-1:0] i_bit2,
  input  logic             i_carry,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry
);

  // Valid-only qualifier, no backpressure: operands are taken on every rising
  // edge where i_valid=1; o_valid marks the cycle a new result is presented.
  logic [WIDTH:0]   carry_w;
  logic [WIDTH-1:0] sum_w;

  assign carry_w[0] = i_carry;

  for (genvar k = 0; k < WIDTH; k++) begin : g_cell
    logic p_w;
    assign p_w          = i_bit1[k] ^ i_bit2[k];
    assign sum_w[k]     = p_w ^ carry_w[k];
    assign carry_w[k+1] = (i_bit1[k] & i_bit2[k]) | (carry_w[k] & p_w);
  end

  if (REGISTERED != 0) begin : g_reg
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             valid_q, valid_d;

    // Result registers hold across idle cycles; only the qualifier drops.
    always_comb begin
      sum_d   = sum_q;
      carry_d = carry_q;
      valid_d = i_valid;
      if (i_valid) begin
        sum_d   = sum_w;
        carry_d = carry_w[WIDTH];
      end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        sum_q   <= '0;
        carry_q <= 1'b0;
        valid_q <= 1'b0;
      end else begin
        sum_q   <= sum_d;
        carry_q <= carry_d;
        valid_q <= valid_d;
      end
    end

    assign o_sum   = sum_q;
    assign o_carry = carry_q;
    assign o_valid = valid_q;
  end else begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = i_clk ^ i_rst_n;

    assign o_sum   = sum_w;
    assign o_carry = carry_w[WIDTH];
    assign o_valid = i_valid;
  end

endmodule

// File: tb/tb_full_adder_unit.sv
// Bench for full_adder_unit: 1-bit and 8-bit registered instances plus a 4-bit combinational one,
// checked against plain integer addition with a hold model for idle cycles.
module tb_full_adder_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       v1, c1, ov1, co1;
  logic [0:0] a1, b1, s1;
  logic       v8, c8, ov8, co8;
  logic [7:0] a8, b8, s8;
  logic       v4, c4, ov4, co4;
  logic [3:0] a4, b4, s4;

  full_adder_unit #(.WIDTH(1), .REGISTERED(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v1), .i_bit1(a1), .i_bit2(b1),
    .i_carry(c1), .o_valid(ov1), .o_sum(s1), .o_carry(co1)
  );

  full_adder_unit #(.WIDTH(8), .REGISTERED(1)) u_dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v8), .i_bit1(a8), .i_bit2(b8),
    .i_carry(c8), .o_valid(ov8), .o_sum(s8), .o_carry(co8)
  );

  full_adder_unit #(.WIDTH(4), .REGISTERED(0)) u_comb4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v4), .i_bit1(a4), .i_bit2(b4),
    .i_carry(c4), .o_valid(ov4), .o_sum(s4), .o_carry(co4)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [8:0] exp_q[$];
  logic [8:0] last8;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Drives one 8-bit beat at the falling edge and checks it one rising edge later.
  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic v);
    logic [8:0] e;
    @(negedge clk);
    a8 = a; b8 = b; c8 = c; v8 = v;
    if (v) exp_q.push_back(9'(a) + 9'(b) + 9'(c));
    @(posedge clk); #1;
    if (v) last8 = exp_q.pop_front();
    e = last8;
    check("add8_sum", 64'(s8), 64'(e[7:0]));
    check("add8_carry", 64'(co8), 64'(e[8]));
    check("add8_valid", 64'(ov8), 64'(v));
  endtask

  task automatic check1(input string tag, input logic s, input logic c, input logic v);
    check({tag, "_sum"}, 64'(s1), 64'(s));
    check({tag, "_carry"}, 64'(co1), 64'(c));
    check({tag, "_valid"}, 64'(ov1), 64'(v));
  endtask

  initial begin
    logic [1:0] e1;
    logic [4:0] e4;
    last8 = '0;
    rst_n = 1'b0;
    v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    v8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; c8 = 1'b1;
    v4 = 1'b0; a4 = '0; b4 = '0; c4 = 1'b0;

    // Reset held across edges with valid high: nothing is captured.
    repeat (2) @(posedge clk);
    #1;
    check1("rst", 1'b0, 1'b0, 1'b0);
    check("rst8_sum", 64'(s8), 64'h0);
    check("rst8_valid", 64'(ov8), 64'h0);

    @(negedge clk);
    rst_n = 1'b1; v1 = 1'b0; v8 = 1'b0;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      {a1, b1, c1} = 3'(i);
      v1 = 1'b1;
      @(posedge clk); #1;
      e1 = 2'(a1) + 2'(b1) + 2'(c1);
      check1("tt", e1[0], e1[1], 1'b1);
    end

    // Capture 1+1+0, then idle with changed inputs: result holds, valid drops.
    @(negedge clk); a1 = 1'b1; b1 = 1'b1; c1 = 1'b0; v1 = 1'b1;
    @(posedge clk); #1;
    check1("hold_cap", 1'b0, 1'b1, 1'b1);
    @(negedge clk); a1 = 1'b0; b1 = 1'b0; c1 = 1'b1; v1 = 1'b0;
    @(posedge clk); #1;
    check1("hold1", 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    check1("hold2", 1'b0, 1'b1, 1'b0);

    // Mid-cycle asynchronous reset with all outputs at 1.
    @(negedge clk); a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; v1 = 1'b1;
    @(posedge clk); #1;
    check1("pre_rst", 1'b1, 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check1("async_rst", 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check1("rst_hold", 1'b0, 1'b0, 1'b0);
    @(negedge clk); rst_n = 1'b1; v1 = 1'b0;
    @(posedge clk); #1;
    check1("post_rst_idle", 1'b0, 1'b0, 1'b0);
    @(negedge clk); a1 = 1'b1; b1 = 1'b0; c1 = 1'b0; v1 = 1'b1;
    @(posedge clk); #1;
    check1("post_rst_cap", 1'b1, 1'b0, 1'b1);
    @(negedge clk); v1 = 1'b0;

    drive8(8'hFF, 8'h01, 1'b0, 1'b1);
    drive8(8'hFF, 8'hFF, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++)
      drive8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b1);
    for (int i = 0; i < 12; i++)
      drive8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
    @(negedge clk); v8 = 1'b0;

    // Combinational instance: settles without any clock edge.
    a4 = 4'h7; b4 = 4'h8; c4 = 1'b1; v4 = 1'b0;
    #1;
    check("comb_sum", 64'(s4), 64'h0);
    check("comb_carry", 64'(co4), 64'h1);
    check("comb_valid0", 64'(ov4), 64'h0);
    v4 = 1'b1;
    #1;
    check("comb_valid1", 64'(ov4), 64'h1);
    for (int i = 0; i < 10; i++) begin
      a4 = 4'($urandom_range(0, 15));
      b4 = 4'($urandom_range(0, 15));
      c4 = 1'($urandom_range(0, 1));
      v4 = 1'($urandom_range(0, 1));
      #1;
      e4 = 5'(a4) + 5'(b4) + 5'(c4);
      check("comb_rnd_sum", 64'(s4), 64'(e4[3:0]));
      check("comb_rnd_carry", 64'(co4), 64'(e4[4]));
      check("comb_rnd_valid", 64'(ov4), 64'(v4));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
